write_buffer: RTL and testbench
===============================

WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered write entries; power of two, at least 2.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 c_a  input  32  cache-side byte address.
REQ-005 c_din  input  32  cache-side write data.
REQ-006 c_strobe  input  1  cache request valid; held stable until c_ready.
REQ-007 c_rw  input  1  1 = write, 0 = read; qualified by c_strobe.
REQ-008 c_dout  output  32  read data to cache; valid when c_ready on a read.
REQ-009 c_ready  output  1  request completes this cycle.
REQ-010 mem_a  output  32  memory address, registered.
REQ-011 mem_dout  output  32  memory write data, registered.
REQ-012 mem_strobe  output  1  memory request valid, registered; held until mem_ready.
REQ-013 mem_rw  output  1  1 = write, 0 = read, registered.
REQ-014 mem_din  input  32  memory read data; valid with mem_ready on a read.
REQ-015 mem_ready  input  1  single-cycle completion pulse for the current memory request.
REQ-016 wb_empty  output  1  high when no entries are buffered and state is IDLE.

Function
REQ-017 The FIFO SHALL hold {word address c_a[31:2], data}, with head, tail and count registers; count ranges 0..DEPTH.
REQ-018 A write (c_strobe & c_rw) SHALL be accepted, with c_ready high combinationally in the same cycle, iff count < DEPTH; the entry is pushed at the edge.
REQ-019 With count == DEPTH, a write SHALL hold c_ready low until a slot frees; same-cycle push-on-pop SHALL NOT be performed.
REQ-020 A read SHALL compare c_a[31:2] against all valid entries, including the entry currently draining.
REQ-021 On a read match, the block SHALL drive c_dout = youngest matching entry data and assert c_ready combinationally in the same cycle; no memory access is made.
REQ-022 FSM states SHALL be IDLE, DRAIN and READ.
REQ-023 In IDLE, an unmatched read SHALL take priority: go to READ with mem_strobe=1, mem_rw=0, mem_a=c_a.
REQ-024 Otherwise, in IDLE with count > 0, the FSM SHALL go to DRAIN with mem_strobe=1, mem_rw=1, mem_a={head addr,2'b00}, mem_dout=head data.
REQ-025 In READ on mem_ready: c_dout = mem_din, c_ready=1 in the same cycle, mem_strobe cleared, next state IDLE.
REQ-026 In DRAIN on mem_ready: head popped, mem_strobe cleared, next state IDLE; one idle cycle precedes the next memory request.
REQ-027 A started memory request SHALL never be aborted; a read arriving during DRAIN waits for completion, then wins in IDLE.
REQ-028 A simultaneous push and pop SHALL leave count unchanged; head and tail wrap modulo DEPTH.
REQ-029 While c_strobe is low, c_ready SHALL be 0.
REQ-030 Memory writes SHALL reach memory in push order.

Reset
REQ-031 On rst: state IDLE, head=tail=count=0, mem_strobe=0, mem_rw=0, mem_a=0, mem_dout=0, wb_empty=1.
REQ-032 Reset mid-transaction SHALL drop the memory request immediately and discard all buffered writes; entry data need not be cleared.

Structure
REQ-033 DEPTH default and the FSM state encoding SHALL live in the shared mips32 package.
REQ-034 One sub-module, write_buffer_fifo (storage, pointers, count, youngest-match forwarding), SHALL be instantiated; the FSM stays in write_buffer.

Verification
REQ-035 Reset, then write 0x100 := 0xDEADBEEF -> c_ready same cycle; DRAIN issues mem_a=0x100, mem_dout=0xDEADBEEF, mem_rw=1; wb_empty=1 after mem_ready.
REQ-036 With mem_ready held low, 5 writes -> first 4 accepted; 5th stalls until the first mem_ready, then accepted on a later cycle.
REQ-037 Writes 0x200 := 1, then 0x200 := 2, then read 0x200 -> c_dout=2, c_ready same cycle, no mem_rw=0 request.
REQ-038 Buffer holds 0x300; read 0x400 in IDLE -> read issued before drain; mem_din=0x55 returned as c_dout with c_ready on mem_ready.
REQ-039 Assert rst during DRAIN -> next cycle mem_strobe=0, count=0, wb_empty=1; following write of 0x500 drains normally.

Source files
------------

// File: rtl/write_buffer_pkg.sv
// write_buffer_pkg: shared depth default and FSM encoding for the write buffer
package write_buffer_pkg;
  localparam int DEPTH_DEF = 4;
  typedef enum logic [1:0] {IDLE, DRAIN, READ} wb_state_t;
endpackage

// File: rtl/write_buffer_if.sv
// write_buffer_if: strobe/ready request bus used for both the cache and memory sides
interface write_buffer_if;
  logic [31:0] a;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        strobe;
  logic        rw;
  logic        ready;
  modport master(output a, wdata, strobe, rw, input rdata, ready);
  modport slave(input a, wdata, strobe, rw, output rdata, ready);
endinterface

// File: rtl/write_buffer_fifo.sv
// write_buffer_fifo: circular write-entry store with youngest-match read forwarding
module write_buffer_fifo
  import write_buffer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [29:0] push_addr,
  input  logic [31:0] push_data,
  input  logic [29:0] look_addr,
  output logic [29:0] head_addr,
  output logic [31:0] head_data,
  output logic        full,
  output logic        empty,
  output logic        hit,
  output logic [31:0] hit_data
);
  logic [29:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;
  assign head_addr = addr_q[head];
  assign head_data = data_q[head];
  assign full      = count == CW'(DEPTH);
  assign empty     = count == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        addr_q[tail] <= push_addr;
        data_q[tail] <= push_data;
        tail         <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // scan oldest to youngest so the last match (the youngest) wins
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count && addr_q[head + AW'(k)] == look_addr) begin
        hit      = 1'b1;
        hit_data = data_q[head + AW'(k)];
      end
    end
  end
endmodule

// File: rtl/write_buffer.sv
// write_buffer: posted-write buffer between cache and memory with read forwarding
module write_buffer
  import write_buffer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic           clk,
  input  logic           rst,
  write_buffer_if.slave  c,
  write_buffer_if.master mem,
  output logic           wb_empty
);
  wb_state_t   state;
  logic        rd, push, pop, full, empty, hit;
  logic [29:0] head_addr;
  logic [31:0] head_data, hit_data;
  assign rd       = c.strobe & ~c.rw;
  assign push     = c.strobe & c.rw & ~full;
  assign pop      = (state == DRAIN) & mem.ready;
  assign c.ready  = push | (rd & (hit | ((state == READ) & mem.ready)));
  assign c.rdata  = hit ? hit_data : mem.rdata;
  assign wb_empty = empty & (state == IDLE);
  write_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .push_addr(c.a[31:2]),
    .push_data(c.wdata),
    .look_addr(c.a[31:2]),
    .head_addr(head_addr),
    .head_data(head_data),
    .full     (full),
    .empty    (empty),
    .hit      (hit),
    .hit_data (hit_data)
  );
  // requests are only launched from IDLE and run to mem.ready; a missing read beats draining
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mem.strobe <= 1'b0;
      mem.rw     <= 1'b0;
      mem.a      <= '0;
      mem.wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rd & ~hit) begin
            state      <= READ;
            mem.strobe <= 1'b1;
            mem.rw     <= 1'b0;
            mem.a      <= c.a;
          end else if (!empty) begin
            state      <= DRAIN;
            mem.strobe <= 1'b1;
            mem.rw     <= 1'b1;
            mem.a      <= {head_addr, 2'b00};
            mem.wdata  <= head_data;
          end
        end
        DRAIN, READ: begin
          if (mem.ready) begin
            state      <= IDLE;
            mem.strobe <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_write_buffer.sv
// tb_write_buffer: directed and random checks of write_buffer against a queue/memory model
module tb_write_buffer;
  localparam int DEPTH = 4;
  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wb_empty;
  always #5 clk = ~clk;
  write_buffer_if c_bus ();
  write_buffer_if m_bus ();
  write_buffer #(.DEPTH(DEPTH)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .c       (c_bus),
    .mem     (m_bus),
    .wb_empty(wb_empty)
  );
  ent_t        wq[$];
  logic [31:0] mem_ref[logic [29:0]];
  logic [31:0] mem_dev[logic [29:0]];
  int          checks = 0;
  int          failures = 0;
  logic        rdy;
  logic [31:0] rdat;
  logic        pend, pw;
  logic [31:0] pa, pd;
  int          age;

  function automatic logic [31:0] dflt(input logic [29:0] a);
    return {2'b00, a} ^ 32'hA5A5_0000;
  endfunction
  function automatic logic [31:0] ref_rd(input logic [29:0] a);
    return mem_ref.exists(a) ? mem_ref[a] : dflt(a);
  endfunction
  function automatic logic [31:0] dev_rd(input logic [29:0] a);
    return mem_dev.exists(a) ? mem_dev[a] : dflt(a);
  endfunction

  task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", t, o, e);
    end
  endtask

  // one clock: drive cache request, answer memory per mode (0 never, 1 always, 2 random), check, update model
  task automatic cyc(input logic s, input logic w, input logic [31:0] a, input logic [31:0] d, input int mode);
    logic        mr, hit;
    logic [31:0] yd;
    ent_t        e;
    @(negedge clk);
    mr = m_bus.strobe && (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0));
    m_bus.ready = mr;
    m_bus.rdata = (m_bus.strobe && !m_bus.rw) ? dev_rd(m_bus.a[31:2]) : $urandom;
    c_bus.strobe = s;
    c_bus.rw = w;
    c_bus.a = a;
    c_bus.wdata = d;
    #1;
    rdy  = c_bus.ready;
    rdat = c_bus.rdata;
    hit  = 1'b0;
    yd   = '0;
    foreach (wq[i]) if (wq[i].a == a[31:2]) begin
      hit = 1'b1;
      yd  = wq[i].d;
    end
    chk("c_ready", rdy, !s ? 1'b0 : w ? (wq.size() < DEPTH) : hit ? 1'b1 : (mr && m_bus.strobe && !m_bus.rw));
    if (s && !w && rdy) chk("c_dout", rdat, hit ? yd : ref_rd(a[31:2]));
    if (s && !w && m_bus.strobe && !m_bus.rw) chk("rd_addr", m_bus.a, a);
    chk("wb_empty", wb_empty, wq.size() == 0 && !m_bus.strobe);
    if (mr && m_bus.strobe && m_bus.rw) begin
      chk("drain_pending", wq.size() > 0, 1);
      if (wq.size() > 0) begin
        chk("drain_addr", m_bus.a, {wq[0].a, 2'b00});
        chk("drain_data", m_bus.wdata, wq[0].d);
        mem_ref[wq[0].a] = wq[0].d;
        void'(wq.pop_front());
      end
      mem_dev[m_bus.a[31:2]] = m_bus.wdata;
    end
    if (s && w && rdy) begin
      e.a = a[31:2];
      e.d = d;
      wq.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    c_bus.strobe = 1'b0;
    m_bus.ready = 1'b0;
    @(negedge clk);
    chk("rst_strobe", m_bus.strobe, 0);
    chk("rst_rw", m_bus.rw, 0);
    chk("rst_a", m_bus.a, 0);
    chk("rst_dout", m_bus.wdata, 0);
    chk("rst_empty", wb_empty, 1);
    chk("rst_ready", c_bus.ready, 0);
    rst = 1'b0;
    wq.delete();
  endtask

  task automatic wait_req(input string t);
    int n = 0;
    while (!m_bus.strobe && n < 10) begin
      cyc(0, 0, 0, 0, 0);
      n++;
    end
    chk({t, "_req"}, m_bus.strobe, 1);
  endtask

  task automatic drain(input string t);
    int n = 0;
    while ((wq.size() > 0 || m_bus.strobe) && n < 60) begin
      cyc(0, 0, 0, 0, 1);
      n++;
    end
    chk({t, "_drained"}, wq.size() == 0 && !m_bus.strobe, 1);
  endtask

  initial begin
    c_bus.strobe = 1'b0;
    c_bus.rw = 1'b0;
    c_bus.a = '0;
    c_bus.wdata = '0;
    m_bus.ready = 1'b0;
    m_bus.rdata = '0;
    do_reset();
    // single write then drain
    cyc(1, 1, 32'h100, 32'hDEADBEEF, 0);
    chk("t1_wr_ready", rdy, 1);
    wait_req("t1");
    chk("t1_mem_a", m_bus.a, 32'h100);
    chk("t1_mem_dout", m_bus.wdata, 32'hDEADBEEF);
    chk("t1_mem_rw", m_bus.rw, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    chk("t1_empty", wb_empty, 1);
    // fill to DEPTH with memory stalled, fifth write waits
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 32'h1000 + 32'(i * 4), 32'(i + 1), 0);
      chk("t2_accept", rdy, 1);
    end
    repeat (3) begin
      cyc(1, 1, 32'h1010, 32'h5, 0);
      chk("t2_stall", rdy, 0);
    end
    chk("t2_draining", m_bus.strobe & m_bus.rw, 1);
    cyc(1, 1, 32'h1010, 32'h5, 1);
    chk("t2_no_push_on_pop", rdy, 0);
    cyc(1, 1, 32'h1010, 32'h5, 0);
    chk("t2_fifth_accepted", rdy, 1);
    drain("t2");
    // youngest-match forwarding
    cyc(1, 1, 32'h200, 32'h1, 0);
    cyc(1, 1, 32'h200, 32'h2, 0);
    cyc(1, 0, 32'h200, 32'h0, 0);
    chk("t3_fwd_ready", rdy, 1);
    chk("t3_fwd_data", rdat, 32'h2);
    repeat (8) begin
      cyc(0, 0, 0, 0, 1);
      chk("t3_no_read", m_bus.strobe & ~m_bus.rw, 0);
    end
    drain("t3");
    // unmatched read wins over pending drain
    mem_ref[30'h100] = 32'h55;
    mem_dev[30'h100] = 32'h55;
    cyc(1, 1, 32'h300, 32'h33, 0);
    cyc(1, 0, 32'h400, 32'h0, 0);
    chk("t4_miss_wait", rdy, 0);
    cyc(1, 0, 32'h400, 32'h0, 0);
    chk("t4_read_first", m_bus.strobe & ~m_bus.rw, 1);
    chk("t4_read_addr", m_bus.a, 32'h400);
    cyc(1, 0, 32'h400, 32'h0, 1);
    chk("t4_read_ready", rdy, 1);
    chk("t4_read_data", rdat, 32'h55);
    drain("t4");
    // reset during drain
    cyc(1, 1, 32'h600, 32'h66, 0);
    wait_req("t5");
    chk("t5_in_drain", m_bus.rw, 1);
    do_reset();
    cyc(1, 1, 32'h500, 32'h77, 0);
    chk("t5_wr_ready", rdy, 1);
    wait_req("t5b");
    chk("t5_mem_a", m_bus.a, 32'h500);
    chk("t5_mem_dout", m_bus.wdata, 32'h77);
    drain("t5");
    // random traffic with random memory latency
    pend = 1'b0;
    pw = 1'b0;
    pa = '0;
    pd = '0;
    age = 0;
    repeat (600) begin
      if (!pend && $urandom_range(0, 9) < 7) begin
        pend = 1'b1;
        pw = 1'($urandom_range(0, 1));
        pa = 32'h2000 + 32'(4 * $urandom_range(0, 7));
        pd = $urandom;
        age = 0;
      end
      cyc(pend, pw, pa, pd, 2);
      if (pend && rdy) pend = 1'b0;
      else if (pend) begin
        age++;
        if (age >= 200) begin
          chk("rand_stall_age", age, 0);
          pend = 1'b0;
        end
      end
    end
    drain("rand");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
